// File: rtl/alu_share_if.sv
// Request/response/ALU bundle between two instruction sources, the arbiter and the shared ALU.
// The arbiter uses the slave modport; sources and the ALU sit on the master side.
interface alu_share_if #(
  parameter int DATA_W = 8,
  parameter int FLAG_W = 4
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [3:0]        req0_opcode;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [3:0]        req1_opcode;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_y;
  logic [FLAG_W-1:0] rsp_flags;
  logic              rsp_err;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic [FLAG_W-1:0] alu_flags;
  logic              busy;

  modport master (
    output req_valid, req0_opcode, req0_a, req0_b, req1_opcode, req1_a, req1_b,
    output rsp_ready, alu_y, alu_flags,
    input  req_ready, rsp_valid, rsp_y, rsp_flags, rsp_err,
    input  alu_opcode, alu_a, alu_b, busy
  );

  modport slave (
    input  req_valid, req0_opcode, req0_a, req0_b, req1_opcode, req1_a, req1_b,
    input  rsp_ready, alu_y, alu_flags,
    output req_ready, rsp_valid, rsp_y, rsp_flags, rsp_err,
    output alu_opcode, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters: issue operands,
// wait a programmable settle time, capture Y/flags and return them to the owner.
module alu_share_arbiter #(
  parameter int DATA_W     = 8,
  parameter int FLAG_W     = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_share_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  logic [1:0]        state_reg;
  logic              owner_reg;
  logic              last_grant_reg;
  logic [3:0]        cnt_reg;
  logic [3:0]        alu_opcode_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic [DATA_W-1:0] rsp_y_reg;
  logic [FLAG_W-1:0] rsp_flags_reg;
  logic              rsp_err_reg;

  logic              grant;
  logic              accept;
  logic              rsp_fire;
  logic [3:0]        sel_opcode;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [1:0]        req_ready_vec;
  logic [1:0]        rsp_valid_vec;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b1110, 4'b1111, 4'b1100, 4'b1000,
      4'b1001, 4'b1010, 4'b1011, 4'b0001, 4'b0000: is_legal = 1'b1;
      default:                                     is_legal = 1'b0;
    endcase
  endfunction

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant = 1'b0;
    if (&bus.req_valid) begin
      grant = ~last_grant_reg;
    end else if (bus.req_valid[1]) begin
      grant = 1'b1;
    end
  end

  assign accept     = (state_reg == ST_IDLE) && bus.req_valid[grant];
  assign rsp_fire   = (state_reg == ST_RESP) && bus.rsp_ready[owner_reg];
  assign sel_opcode = grant ? bus.req1_opcode : bus.req0_opcode;
  assign sel_a      = grant ? bus.req1_a : bus.req0_a;
  assign sel_b      = grant ? bus.req1_b : bus.req0_b;

  always_comb begin
    req_ready_vec = 2'b00;
    rsp_valid_vec = 2'b00;
    if (accept) begin
      req_ready_vec[grant] = 1'b1;
    end
    if (state_reg == ST_RESP) begin
      rsp_valid_vec[owner_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
      alu_opcode_reg <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      rsp_y_reg      <= '0;
      rsp_flags_reg  <= '0;
      rsp_err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            owner_reg      <= grant;
            last_grant_reg <= grant;
            if (is_legal(sel_opcode)) begin
              alu_opcode_reg <= sel_opcode;
              alu_a_reg      <= sel_a;
              alu_b_reg      <= sel_b;
              cnt_reg        <= SETTLE_LOAD;
              state_reg      <= ST_EXEC;
            end else begin
              // Illegal opcodes never reach the ALU; answer immediately with an error.
              rsp_y_reg     <= '0;
              rsp_flags_reg <= '0;
              rsp_err_reg   <= 1'b1;
              state_reg     <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_reg == 4'd0) begin
            rsp_y_reg     <= bus.alu_y;
            rsp_flags_reg <= bus.alu_flags;
            rsp_err_reg   <= 1'b0;
            state_reg     <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_fire) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_vec;
  assign bus.rsp_valid  = rsp_valid_vec;
  assign bus.rsp_y      = rsp_y_reg;
  assign bus.rsp_flags  = rsp_flags_reg;
  assign bus.rsp_err    = rsp_err_reg;
  assign bus.alu_opcode = alu_opcode_reg;
  assign bus.alu_a      = alu_a_reg;
  assign bus.alu_b      = alu_b_reg;
  assign bus.busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: one arbiter with a 1-cycle settle and one with a 4-cycle settle,
// each driving a small reference ALU (flags = {zero, negative, carry, overflow}).
module tb_alu_share_arbiter;

  logic clk;
  logic rst;
  logic ovr4;
  int   n_cmp;
  int   n_bad;

  alu_share_if #(.DATA_W(8), .FLAG_W(4)) b1 ();
  alu_share_if #(.DATA_W(8), .FLAG_W(4)) b4 ();

  alu_share_arbiter #(.DATA_W(8), .FLAG_W(4), .SETTLE_CYC(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  alu_share_arbiter #(.DATA_W(8), .FLAG_W(4), .SETTLE_CYC(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  w;
    logic [15:0] m;
    logic        v;
    w = '0;
    m = '0;
    v = 1'b0;
    case (op)
      4'b1110: begin w = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (w[7] != a[7]); end
      4'b1111: begin w = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (w[7] != a[7]); end
      4'b1100: begin m = {8'd0, a} * {8'd0, b}; w = {|m[15:8], m[7:0]}; end
      4'b1000: w = {1'b0, ~a};
      4'b1001: w = {1'b0, a ^ b};
      4'b1010: w = {1'b0, a | b};
      4'b1011: w = {1'b0, a & b};
      4'b0001: w = {a, 1'b0};
      4'b0000: w = {a[0], 1'b0, a[7:1]};
      default: w = '0;
    endcase
    return {(w[7:0] == 8'd0), w[7], w[8], v, w[7:0]};
  endfunction

  logic [11:0] ref1;
  logic [11:0] ref4;
  assign ref1         = alu_ref(b1.alu_opcode, b1.alu_a, b1.alu_b);
  assign ref4         = alu_ref(b4.alu_opcode, b4.alu_a, b4.alu_b);
  assign b1.alu_y     = ref1[7:0];
  assign b1.alu_flags = ref1[11:8];
  assign b4.alu_y     = ovr4 ? 8'hA5 : ref4[7:0];
  assign b4.alu_flags = ovr4 ? 4'hF : ref4[11:8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put1(input logic idx, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (idx) begin
      b1.req1_opcode = op; b1.req1_a = a; b1.req1_b = b;
    end else begin
      b1.req0_opcode = op; b1.req0_a = a; b1.req0_b = b;
    end
    b1.req_valid[idx] = 1'b1;
  endtask

  task automatic put4(input logic idx, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (idx) begin
      b4.req1_opcode = op; b4.req1_a = a; b4.req1_b = b;
    end else begin
      b4.req0_opcode = op; b4.req0_a = a; b4.req0_b = b;
    end
    b4.req_valid[idx] = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    ovr4  = 1'b0;
    b1.req_valid = 2'b00; b1.rsp_ready = 2'b00;
    b1.req0_opcode = '0; b1.req0_a = '0; b1.req0_b = '0;
    b1.req1_opcode = '0; b1.req1_a = '0; b1.req1_b = '0;
    b4.req_valid = 2'b00; b4.rsp_ready = 2'b00;
    b4.req0_opcode = '0; b4.req0_a = '0; b4.req0_b = '0;
    b4.req1_opcode = '0; b4.req1_a = '0; b4.req1_b = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_req_ready", 32'(b1.req_ready), 0);
    chk("rst_rsp_valid", 32'(b1.rsp_valid), 0);
    chk("rst_rsp_y", 32'(b1.rsp_y), 0);
    chk("rst_rsp_flags", 32'(b1.rsp_flags), 0);
    chk("rst_rsp_err", 32'(b1.rsp_err), 0);
    chk("rst_alu_opcode", 32'(b1.alu_opcode), 0);
    chk("rst_alu_a", 32'(b1.alu_a), 0);
    chk("rst_alu_b", 32'(b1.alu_b), 0);
    chk("rst_busy", 32'(b1.busy), 0);
    rst = 1'b0;
    cyc();

    // req0 sub 75-75, settle 1
    put1(1'b0, 4'b1111, 8'd75, 8'd75);
    #1 chk("t1_req_ready", 32'(b1.req_ready), 32'h1);
    cyc();
    b1.req_valid = 2'b00;
    chk("t1_alu_a", 32'(b1.alu_a), 75);
    chk("t1_alu_b", 32'(b1.alu_b), 75);
    chk("t1_alu_opcode", 32'(b1.alu_opcode), 32'hF);
    chk("t1_busy", 32'(b1.busy), 1);
    chk("t1_exec_no_rsp", 32'(b1.rsp_valid), 0);
    b1.rsp_ready = 2'b10;
    cyc();
    chk("t1_rsp_valid", 32'(b1.rsp_valid), 32'h1);
    chk("t1_rsp_y", 32'(b1.rsp_y), 0);
    chk("t1_rsp_flags", 32'(b1.rsp_flags), 32'h8);
    chk("t1_rsp_err", 32'(b1.rsp_err), 0);
    cyc();
    chk("t1_nonowner_ready_ignored", 32'(b1.rsp_valid), 32'h1);
    b1.rsp_ready = 2'b01;
    cyc();
    chk("t1_rsp_done", 32'(b1.rsp_valid), 0);
    chk("t1_idle", 32'(b1.busy), 0);
    b1.rsp_ready = 2'b00;

    // Illegal opcode from req1
    put1(1'b1, 4'b0100, 8'd3, 8'd4);
    #1 chk("ill_req_ready", 32'(b1.req_ready), 32'h2);
    cyc();
    b1.req_valid = 2'b00;
    chk("ill_rsp_valid", 32'(b1.rsp_valid), 32'h2);
    chk("ill_rsp_y", 32'(b1.rsp_y), 0);
    chk("ill_rsp_flags", 32'(b1.rsp_flags), 0);
    chk("ill_rsp_err", 32'(b1.rsp_err), 1);
    chk("ill_alu_a", 32'(b1.alu_a), 75);
    chk("ill_alu_b", 32'(b1.alu_b), 75);
    chk("ill_alu_opcode", 32'(b1.alu_opcode), 32'hF);
    b1.rsp_ready = 2'b10;
    cyc();
    chk("ill_rsp_done", 32'(b1.rsp_valid), 0);
    b1.rsp_ready = 2'b00;

    // Tie: last grant was req1, so req0 goes first
    put1(1'b0, 4'b1110, 8'd75, 8'd31);
    put1(1'b1, 4'b1111, 8'd75, 8'd31);
    #1 chk("tie_req_ready", 32'(b1.req_ready), 32'h1);
    cyc();
    b1.req_valid[0] = 1'b0;
    chk("tie_busy_ready", 32'(b1.req_ready), 0);
    cyc();
    chk("tie_rsp0_valid", 32'(b1.rsp_valid), 32'h1);
    chk("tie_rsp0_y", 32'(b1.rsp_y), 106);
    chk("tie_rsp0_flags", 32'(b1.rsp_flags), 0);
    b1.rsp_ready = 2'b01;
    cyc();
    b1.rsp_ready = 2'b00;
    chk("tie_req1_ready", 32'(b1.req_ready), 32'h2);
    cyc();
    b1.req_valid = 2'b00;
    cyc();
    chk("tie_rsp1_valid", 32'(b1.rsp_valid), 32'h2);
    chk("tie_rsp1_y", 32'(b1.rsp_y), 44);
    b1.rsp_ready = 2'b10;
    cyc();
    b1.rsp_ready = 2'b00;

    // Backpressure on req0 while req1 waits
    put1(1'b0, 4'b1110, 8'd200, 8'd100);
    #1 chk("bp_req_ready", 32'(b1.req_ready), 32'h1);
    cyc();
    b1.req_valid = 2'b00;
    put1(1'b1, 4'b1011, 8'hF0, 8'h3C);
    cyc();
    chk("bp_rsp_valid", 32'(b1.rsp_valid), 32'h1);
    chk("bp_rsp_y", 32'(b1.rsp_y), 32'h2C);
    chk("bp_rsp_flags", 32'(b1.rsp_flags), 32'h2);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_hold_valid", 32'(b1.rsp_valid), 32'h1);
      chk("bp_hold_y", 32'(b1.rsp_y), 32'h2C);
      chk("bp_hold_flags", 32'(b1.rsp_flags), 32'h2);
      chk("bp_hold_req_ready", 32'(b1.req_ready), 0);
      chk("bp_hold_busy", 32'(b1.busy), 1);
    end
    b1.rsp_ready = 2'b01;
    cyc();
    b1.rsp_ready = 2'b00;
    chk("bp_done", 32'(b1.rsp_valid), 0);
    chk("bp_req1_ready", 32'(b1.req_ready), 32'h2);
    cyc();
    b1.req_valid = 2'b00;
    chk("bp_req1_alu_a", 32'(b1.alu_a), 32'hF0);
    cyc();
    chk("bp_req1_rsp_valid", 32'(b1.rsp_valid), 32'h2);
    chk("bp_req1_rsp_y", 32'(b1.rsp_y), 32'h30);
    b1.rsp_ready = 2'b10;
    cyc();
    b1.rsp_ready = 2'b00;

    // req0 xor alone, leaves last grant on req0
    put1(1'b0, 4'b1001, 8'h0F, 8'hFF);
    cyc();
    b1.req_valid = 2'b00;
    cyc();
    chk("xor_rsp_y", 32'(b1.rsp_y), 32'hF0);
    chk("xor_rsp_flags", 32'(b1.rsp_flags), 32'h4);
    b1.rsp_ready = 2'b01;
    cyc();
    b1.rsp_ready = 2'b00;

    // Repeat tie now favours req1
    put1(1'b0, 4'b1110, 8'd1, 8'd2);
    put1(1'b1, 4'b1110, 8'd3, 8'd4);
    #1 chk("tie2_req_ready", 32'(b1.req_ready), 32'h2);
    cyc();
    b1.req_valid[1] = 1'b0;
    chk("tie2_alu_a", 32'(b1.alu_a), 3);
    cyc();
    chk("tie2_rsp1_valid", 32'(b1.rsp_valid), 32'h2);
    chk("tie2_rsp1_y", 32'(b1.rsp_y), 7);
    b1.rsp_ready = 2'b10;
    cyc();
    b1.rsp_ready = 2'b00;
    chk("tie2_req0_ready", 32'(b1.req_ready), 32'h1);
    cyc();
    b1.req_valid = 2'b00;
    cyc();
    chk("tie2_rsp0_y", 32'(b1.rsp_y), 3);
    b1.rsp_ready = 2'b01;
    cyc();
    b1.rsp_ready = 2'b00;

    // Settle 4: mul 5*6, ALU output disturbed except in the final EXEC cycle
    put4(1'b0, 4'b1100, 8'd5, 8'd6);
    #1 chk("s4_req_ready", 32'(b4.req_ready), 32'h1);
    cyc();
    b4.req_valid = 2'b00;
    ovr4 = 1'b1;
    chk("s4_alu_a", 32'(b4.alu_a), 5);
    chk("s4_alu_b", 32'(b4.alu_b), 6);
    chk("s4_alu_opcode", 32'(b4.alu_opcode), 32'hC);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("s4_hold_alu_a", 32'(b4.alu_a), 5);
      chk("s4_hold_alu_b", 32'(b4.alu_b), 6);
      chk("s4_no_rsp_yet", 32'(b4.rsp_valid), 0);
    end
    ovr4 = 1'b0;
    cyc();
    chk("s4_rsp_valid", 32'(b4.rsp_valid), 32'h1);
    chk("s4_rsp_y", 32'(b4.rsp_y), 30);
    chk("s4_rsp_flags", 32'(b4.rsp_flags), 0);
    b4.rsp_ready = 2'b01;
    cyc();
    b4.rsp_ready = 2'b00;
    chk("s4_done", 32'(b4.rsp_valid), 0);

    // Reset in the middle of EXEC
    put4(1'b1, 4'b1110, 8'd9, 8'd9);
    cyc();
    b4.req_valid = 2'b00;
    cyc();
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(b4.busy), 0);
    chk("mrst_alu_a", 32'(b4.alu_a), 0);
    chk("mrst_alu_opcode", 32'(b4.alu_opcode), 0);
    chk("mrst_rsp_y", 32'(b4.rsp_y), 0);
    chk("mrst_rsp_valid", 32'(b4.rsp_valid), 0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("mrst_no_rsp", 32'(b4.rsp_valid), 0);
    end
    put4(1'b0, 4'b1110, 8'd1, 8'd1);
    put4(1'b1, 4'b1110, 8'd2, 8'd2);
    #1 chk("mrst_tie_ready", 32'(b4.req_ready), 32'h1);
    cyc();
    b4.req_valid[0] = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("mrst_rsp0_valid", 32'(b4.rsp_valid), 32'h1);
    chk("mrst_rsp0_y", 32'(b4.rsp_y), 2);
    b4.rsp_ready = 2'b01;
    cyc();
    b4.rsp_ready = 2'b00;
    chk("mrst_req1_ready", 32'(b4.req_ready), 32'h2);
    b4.req_valid = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
